// File: rtl/cruise_pkg.sv
// Shared state encodings and default datapath constants for the cruise-control sequencer.
package cruise_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccel  = 2'b01,
    StBrake  = 2'b10,
    StCruise = 2'b11
  } cruise_state_e;

  localparam int unsigned DefSpeedW    = 8;
  localparam int unsigned DefMaxSpeed  = 200;
  localparam int unsigned DefMinCruise = 40;
  localparam int unsigned DefAccStep   = 2;
  localparam int unsigned DefBrkStep   = 4;

endpackage

// File: rtl/cruise_speed_reg.sv
// Saturating vehicle-speed register: updates on tick according to the current mode,
// stepping toward the set-point while cruising.
module cruise_speed_reg
  import cruise_pkg::*;
#(
  parameter int unsigned SPEED_W   = DefSpeedW,
  parameter int unsigned MAX_SPEED = DefMaxSpeed,
  parameter int unsigned ACC_STEP  = DefAccStep,
  parameter int unsigned BRK_STEP  = DefBrkStep
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic [1:0]         mode_i,
  input  logic [SPEED_W-1:0] set_point_i,
  output logic [SPEED_W-1:0] speed_o
);

  localparam int unsigned ExtW = SPEED_W + 1;

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W:0]   speed_ext, inc_ext, dec1_ext, decb_ext;

  // One extra bit so overflow and borrow are visible before clamping.
  assign speed_ext = {1'b0, speed_q};
  assign inc_ext   = speed_ext + ExtW'(ACC_STEP);
  assign dec1_ext  = speed_ext - ExtW'(1);
  assign decb_ext  = speed_ext - ExtW'(BRK_STEP);

  always_comb begin
    speed_d = speed_q;
    if (tick_i) begin
      case (cruise_state_e'(mode_i))
        StIdle:  speed_d = dec1_ext[SPEED_W] ? '0 : dec1_ext[SPEED_W-1:0];
        StAccel: speed_d = (inc_ext > ExtW'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                        : inc_ext[SPEED_W-1:0];
        StBrake: speed_d = decb_ext[SPEED_W] ? '0 : decb_ext[SPEED_W-1:0];
        StCruise: begin
          if (speed_q < set_point_i) begin
            speed_d = speed_q + SPEED_W'(1);
          end else if (speed_q > set_point_i) begin
            speed_d = speed_q - SPEED_W'(1);
          end
        end
        default: speed_d = speed_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      speed_q <= '0;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign speed_o = speed_q;

endmodule

// File: rtl/cruise_jk_sequencer.sv
// Next-state and JK excitation for the external cruise state flip-flops, plus set-point capture.
// Optional CRUISE_RESUME_EN: remembers a captured set-point so IDLE can resume it on the button.
module cruise_jk_sequencer
  import cruise_pkg::*;
#(
  parameter int unsigned SPEED_W    = DefSpeedW,
  parameter int unsigned MAX_SPEED  = DefMaxSpeed,
  parameter int unsigned MIN_CRUISE = DefMinCruise,
  parameter int unsigned ACC_STEP   = DefAccStep,
  parameter int unsigned BRK_STEP   = DefBrkStep
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               tick,
  input  logic               accel,
  input  logic               brake,
  input  logic               cancel,
  input  logic               cruise_btn,
  input  logic [1:0]         state_q,
  output logic [1:0]         j,
  output logic [1:0]         k,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] cruise_speed,
  output logic               cruise_active
);

  cruise_state_e      cur_st, nxt_st;
  logic [1:0]         nxt_bits;
  logic               btn_prev_q, btn_prev_d;
  logic               btn_rise;
  logic               capture;
  logic [SPEED_W-1:0] cruise_speed_q, cruise_speed_d;

`ifdef CRUISE_RESUME_EN
  logic cruise_valid_q, cruise_valid_d;
`endif

  assign cur_st   = cruise_state_e'(state_q);
  assign btn_rise = cruise_btn & ~btn_prev_q;

  // Register process: the state itself lives in the external JK flip-flops.
  always_ff @(posedge clk) begin
    if (clear) begin
      btn_prev_q     <= 1'b0;
      cruise_speed_q <= '0;
`ifdef CRUISE_RESUME_EN
      cruise_valid_q <= 1'b0;
`endif
    end else begin
      btn_prev_q     <= btn_prev_d;
      cruise_speed_q <= cruise_speed_d;
`ifdef CRUISE_RESUME_EN
      cruise_valid_q <= cruise_valid_d;
`endif
    end
  end

  // Next-state decision; pedals and cancel outrank the button, which is then consumed.
  always_comb begin
    nxt_st  = cur_st;
    capture = 1'b0;
    if (brake) begin
      nxt_st = StBrake;
    end else if (cancel) begin
      nxt_st = StIdle;
    end else if (accel) begin
      nxt_st = StAccel;
    end else if (btn_rise && (cur_st == StCruise)) begin
      nxt_st = StIdle;
`ifdef CRUISE_RESUME_EN
    end else if (btn_rise && (cur_st == StIdle) && cruise_valid_q) begin
      nxt_st = StCruise;
`endif
    end else if (btn_rise && ((cur_st == StIdle) || (cur_st == StAccel)) &&
                 (speed >= SPEED_W'(MIN_CRUISE))) begin
      nxt_st  = StCruise;
      capture = 1'b1;
    end else if ((cur_st == StBrake) || (cur_st == StAccel)) begin
      nxt_st = StIdle;
    end
  end

  always_comb begin
    btn_prev_d     = cruise_btn;
    cruise_speed_d = capture ? speed : cruise_speed_q;
`ifdef CRUISE_RESUME_EN
    cruise_valid_d = cruise_valid_q | capture;
`endif
  end

  // Output process: set/reset-only excitation, so J and K are never both high.
  always_comb begin
    nxt_bits = nxt_st;
    j        = 2'b00;
    k        = 2'b00;
    if (!clear) begin
      j = nxt_bits & ~state_q;
      k = ~nxt_bits & state_q;
    end
  end

  cruise_speed_reg #(
    .SPEED_W   (SPEED_W),
    .MAX_SPEED (MAX_SPEED),
    .ACC_STEP  (ACC_STEP),
    .BRK_STEP  (BRK_STEP)
  ) u_speed_reg (
    .clk_i       (clk),
    .clear_i     (clear),
    .tick_i      (tick),
    .mode_i      (state_q),
    .set_point_i (cruise_speed_q),
    .speed_o     (speed)
  );

  assign cruise_speed  = cruise_speed_q;
  assign cruise_active = (cur_st == StCruise);

endmodule
